// File: rtl/wb_bus_master_if.sv
// rtl/wb_bus_master_if.sv - command/response and Wishbone signal bundle for wb_bus_master
interface wb_bus_master_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic            i_cmd_we;
  logic [AW-1:0]   i_cmd_addr;
  logic [DW-1:0]   i_cmd_data;
  logic [DW/8-1:0] i_cmd_sel;

  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [DW-1:0]   o_rsp_data;
  logic            o_rsp_err;
  logic            o_rsp_timeout;

  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_ack;
  logic            i_wb_stall;
  logic            i_wb_err;
  logic [DW-1:0]   i_wb_data;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
    input  i_rsp_ready,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
    output i_rsp_ready,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/wb_bus_master.sv
// rtl/wb_bus_master.sv - single-outstanding Wishbone B4 pipelined initiator with timeout
module wb_bus_master #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wb_bus_master_if.master bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic            cyc_q, stb_q, we_q;
  logic            cyc_n, stb_n, we_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   data_q, data_n;
  logic [DW/8-1:0] sel_q, sel_n;
  logic            rsp_valid_q, rsp_err_q, rsp_to_q;
  logic            rsp_valid_n, rsp_err_n, rsp_to_n;
  logic [DW-1:0]   rsp_data_q, rsp_data_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            got;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc_q;
    stb_n       = stb_q;
    we_n        = we_q;
    addr_n      = addr_q;
    data_n      = data_q;
    sel_n       = sel_q;
    rsp_valid_n = rsp_valid_q;
    rsp_err_n   = rsp_err_q;
    rsp_to_n    = rsp_to_q;
    rsp_data_n  = rsp_data_q;
    cnt_n       = cnt_q;
    got         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_cmd_valid) begin
          we_n    = bus.i_cmd_we;
          addr_n  = bus.i_cmd_addr;
          data_n  = bus.i_cmd_data;
          sel_n   = bus.i_cmd_sel;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ, WAIT: begin
        cnt_n = cnt_q + 1'b1;
        // Slave responses only count once the strobe has been taken.
        got = (bus.i_wb_ack | bus.i_wb_err) & ((state == WAIT) | ~bus.i_wb_stall);
        if (state == REQ && !bus.i_wb_stall) begin
          stb_n   = 1'b0;
          state_n = WAIT;
        end
        if (got || cnt_q == LAST) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = got & bus.i_wb_err;
          rsp_to_n    = ~got;
          rsp_data_n  = (got && !bus.i_wb_err && !we_q) ? bus.i_wb_data : '0;
          state_n     = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      cyc_q       <= cyc_n;
      stb_q       <= stb_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      sel_q       <= sel_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rsp_to_q    <= rsp_to_n;
      rsp_data_q  <= rsp_data_n;
      cnt_q       <= cnt_n;
    end
  end

  assign bus.o_cmd_ready   = (state == IDLE);
  assign bus.o_wb_cyc      = cyc_q;
  assign bus.o_wb_stb      = stb_q;
  assign bus.o_wb_we       = we_q;
  assign bus.o_wb_addr     = addr_q;
  assign bus.o_wb_data     = data_q;
  assign bus.o_wb_sel      = sel_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_timeout = rsp_to_q;
endmodule
